// File: rtl/dmem_view_ctrl_pkg.sv
// Shared types and constants for the post-run data-memory viewer.
package dmem_view_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_CORE,
    ST_HDR,
    ST_EMPTY,
    ST_FETCH,
    ST_CAP,
    ST_SHOW
  } state_t;

  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;

  // Area count lives in the top byte of the header word at address 0.
  localparam int unsigned HDR_MSB = 31;
  localparam int unsigned HDR_LSB = 24;

endpackage

// File: rtl/dmem_view_ctrl_btn_edge.sv
// Two-channel rising-edge detector; rise pulses for one cycle per 0->1 transition.
module dmem_view_ctrl_btn_edge (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] btn,
  output logic [1:0] rise
);

  logic [1:0] hist;

  always_ff @(posedge clk) begin
    if (reset) hist <= '0;
    else       hist <= btn;
  end

  assign rise = btn & ~hist;

endmodule

// File: rtl/dmem_view_ctrl.sv
// Data-memory port owner: passes core addresses while running, then sequences result readout.
module dmem_view_ctrl
  import dmem_view_ctrl_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = BASE_ADDR_DEFAULT,
  parameter int unsigned IDX_W      = 8,
  parameter int unsigned AUTO_TICKS = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             finish,
  input  logic [31:0]      core_daddr,
  input  logic [31:0]      dmem_rd,
  input  logic [1:0]       btn,
  input  logic             auto_en,
  output logic [31:0]      dmem_addr,
  output logic [IDX_W-1:0] num_areas,
  output logic [IDX_W-1:0] view_index,
  output logic [31:0]      view_data,
  output logic             view_valid,
  output logic             core_owns
);

  localparam int unsigned TW = $clog2(AUTO_TICKS);

  state_t           state, state_nx;
  logic [TW-1:0]    timer;
  logic [1:0]       rise;
  logic             btn_next, btn_prev, btn_step, tmr_fire, step, step_fwd;
  logic [IDX_W-1:0] hdr_count, idx_last, idx_stepped;
  logic [31:0]      entry_addr;

  dmem_view_ctrl_btn_edge u_btn_edge (
    .clk   (clk),
    .reset (reset),
    .btn   (btn),
    .rise  (rise)
  );

  assign btn_next = rise[0] & ~rise[1];
  assign btn_prev = rise[1] & ~rise[0];
  assign btn_step = btn_next | btn_prev;
  assign tmr_fire = auto_en && (timer == TW'(AUTO_TICKS - 1));
  assign step     = btn_step | tmr_fire;
  // Button direction wins over a coincident timer expiry.
  assign step_fwd = btn_step ? btn_next : 1'b1;

  assign hdr_count  = IDX_W'(dmem_rd[HDR_MSB:HDR_LSB]);
  assign idx_last   = num_areas - IDX_W'(1);
  assign entry_addr = BASE_ADDR + 32'({view_index, 2'b00});
  assign core_owns  = (state == ST_CORE);

  always_comb begin
    idx_stepped = view_index;
    if (step_fwd) idx_stepped = (view_index == idx_last) ? '0 : view_index + IDX_W'(1);
    else          idx_stepped = (view_index == '0) ? idx_last : view_index - IDX_W'(1);
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_CORE:  if (finish) state_nx = ST_HDR;
      ST_HDR: begin
        if (!finish)              state_nx = ST_CORE;
        else if (hdr_count != '0) state_nx = ST_FETCH;
        else                      state_nx = ST_EMPTY;
      end
      ST_EMPTY: if (!finish) state_nx = ST_CORE;
      ST_FETCH: state_nx = finish ? ST_CAP : ST_CORE;
      ST_CAP:   state_nx = finish ? ST_SHOW : ST_CORE;
      ST_SHOW: begin
        if (!finish)  state_nx = ST_CORE;
        else if (step) state_nx = ST_FETCH;
      end
      default:  state_nx = ST_CORE;
    endcase
  end

  always_comb begin
    dmem_addr = entry_addr;
    case (state)
      ST_CORE:          dmem_addr = core_daddr;
      ST_HDR, ST_EMPTY: dmem_addr = '0;
      default:          dmem_addr = entry_addr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_CORE;
      num_areas  <= '0;
      view_index <= '0;
      view_data  <= '0;
      view_valid <= 1'b0;
      timer      <= '0;
    end else begin
      state <= state_nx;
      // Valid exactly while resident in SHOW; every other path clears it.
      view_valid <= (state_nx == ST_SHOW);
      if (state == ST_HDR && finish) begin
        num_areas  <= hdr_count;
        view_index <= '0;
      end
      if (state == ST_CAP && finish) view_data <= dmem_rd;
      if (state == ST_SHOW && finish && step) view_index <= idx_stepped;
      if (state == ST_SHOW && auto_en && !step) timer <= timer + TW'(1);
      else                                      timer <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_view_ctrl.sv
// Self-checking bench for dmem_view_ctrl: directed tables plus randomized browsing against a modulo model.
module tb_dmem_view_ctrl;

  logic        clk = 1'b0;
  logic        reset, finish, auto_en;
  logic [31:0] core_daddr, dmem_rd, dmem_addr, view_data;
  logic [1:0]  btn;
  logic [7:0]  num_areas, view_index;
  logic        view_valid, core_owns;

  logic [31:0] mem [512];
  assign dmem_rd = mem[dmem_addr[10:2]];

  always #5 clk = ~clk;

  dmem_view_ctrl #(
    .BASE_ADDR  (32'd1024),
    .IDX_W      (8),
    .AUTO_TICKS (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .finish     (finish),
    .core_daddr (core_daddr),
    .dmem_rd    (dmem_rd),
    .btn        (btn),
    .auto_en    (auto_en),
    .dmem_addr  (dmem_addr),
    .num_areas  (num_areas),
    .view_index (view_index),
    .view_data  (view_data),
    .view_valid (view_valid),
    .core_owns  (core_owns)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [1:0] b);
    btn = b;
    tick();
    btn = 2'b00;
  endtask

  typedef struct {
    logic [1:0]  b;
    logic [7:0]  idx;
    logic [31:0] data;
    logic        drop;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int idx, n, k, kind;

    tbl[0] = '{2'b01, 8'd1, 32'd6, 1'b1};
    tbl[1] = '{2'b01, 8'd2, 32'd7, 1'b1};
    tbl[2] = '{2'b01, 8'd0, 32'd5, 1'b1};
    tbl[3] = '{2'b10, 8'd2, 32'd7, 1'b1};
    tbl[4] = '{2'b11, 8'd2, 32'd7, 1'b0};
    tbl[5] = '{2'b10, 8'd1, 32'd6, 1'b1};
    tbl[6] = '{2'b10, 8'd0, 32'd5, 1'b1};

    for (int i = 0; i < 512; i++) mem[i] = '0;
    reset = 1'b1; finish = 1'b0; auto_en = 1'b0; btn = 2'b00;
    core_daddr = 32'h0000_1234;
    tick(2);
    reset = 1'b0;
    tick();

    chk("rst_addr", dmem_addr, 32'h1234);
    chk("rst_owns", core_owns, 1);
    chk("rst_valid", view_valid, 0);
    chk("rst_areas", num_areas, 0);
    chk("rst_index", view_index, 0);
    chk("rst_data", view_data, 0);

    // First readout: three entries, four-cycle latency
    mem[0] = 32'h0300_0000; mem[256] = 32'd5; mem[257] = 32'd6; mem[258] = 32'd7;
    finish = 1'b1;
    tick();
    chk("hdr_addr", dmem_addr, 0);
    chk("hdr_owns", core_owns, 0);
    tick();
    chk("fetch_areas", num_areas, 3);
    chk("fetch_addr", dmem_addr, 1024);
    chk("fetch_valid", view_valid, 0);
    tick();
    chk("cap_valid", view_valid, 0);
    tick();
    chk("show_valid", view_valid, 1);
    chk("show_data", view_data, 5);
    chk("show_addr", dmem_addr, 1024);

    for (int i = 0; i < 7; i++) begin
      press(tbl[i].b);
      chk("tbl_drop", view_valid, !tbl[i].drop);
      tick(3);
      chk("tbl_valid", view_valid, 1);
      chk("tbl_index", view_index, tbl[i].idx);
      chk("tbl_data", view_data, tbl[i].data);
      chk("tbl_addr", dmem_addr, 1024 + 4 * tbl[i].idx);
    end

    // Auto-scroll: 4 SHOW cycles then 2 fetch cycles per step
    auto_en = 1'b1;
    idx = 0;
    for (int r = 0; r < 3; r++) begin
      tick(3);
      chk("auto_hold_valid", view_valid, 1);
      chk("auto_hold_index", view_index, idx);
      tick();
      idx = (idx + 1) % 3;
      chk("auto_step_valid", view_valid, 0);
      chk("auto_step_index", view_index, idx);
      tick(2);
      chk("auto_show_valid", view_valid, 1);
      chk("auto_show_data", view_data, 5 + idx);
    end
    tick(3);
    btn = 2'b01;
    tick();
    btn = 2'b00;
    chk("prio_index", view_index, 1);
    chk("prio_valid", view_valid, 0);
    tick(2);
    chk("prio_show_index", view_index, 1);
    chk("prio_show_data", view_data, 6);
    tick(3);
    chk("prio_rearm_index", view_index, 1);
    tick();
    chk("prio_next_index", view_index, 2);
    auto_en = 1'b0;
    tick(3);

    // Core restart from SHOW, then header re-read
    finish = 1'b0; core_daddr = 32'h0000_ABCD;
    tick();
    chk("restart_owns", core_owns, 1);
    chk("restart_addr", dmem_addr, 32'hABCD);
    chk("restart_valid", view_valid, 0);
    chk("restart_areas", num_areas, 3);
    chk("restart_index", view_index, 2);
    mem[0] = 32'h0200_00FF; mem[256] = 32'h11; mem[257] = 32'h22;
    finish = 1'b1;
    tick(4);
    chk("reread_areas", num_areas, 2);
    chk("reread_index", view_index, 0);
    chk("reread_valid", view_valid, 1);
    chk("reread_data", view_data, 32'h11);

    // Randomized browsing against a modulo-arithmetic model
    for (int r = 0; r < 6; r++) begin
      n = (r == 0) ? 1 : $urandom_range(2, 12);
      mem[0] = {8'(n), 24'($urandom)};
      for (int e = 0; e < n; e++) mem[256 + e] = $urandom;
      finish = 1'b0;
      tick();
      finish = 1'b1;
      k = 0;
      tick();
      while (!view_valid && k < 20) begin
        tick();
        k++;
      end
      chk("rnd_start_timeout", k < 20, 1);
      chk("rnd_areas", num_areas, n);
      idx = 0;
      chk("rnd_start_data", view_data, mem[256]);
      for (int p = 0; p < 10; p++) begin
        kind = $urandom_range(0, 2);
        case (kind)
          0: begin press(2'b01); idx = (idx + 1) % n; end
          1: begin press(2'b10); idx = (idx + n - 1) % n; end
          default: press(2'b11);
        endcase
        chk("rnd_drop", view_valid, kind == 2);
        tick(3);
        chk("rnd_valid", view_valid, 1);
        chk("rnd_index", view_index, idx);
        chk("rnd_data", view_data, mem[256 + idx]);
      end
    end

    // Empty header: buttons ignored, address parked at 0
    mem[0] = 32'h00FF_FFFF;
    finish = 1'b0;
    tick();
    finish = 1'b1;
    tick(2);
    chk("empty_areas", num_areas, 0);
    chk("empty_addr", dmem_addr, 0);
    chk("empty_valid", view_valid, 0);
    chk("empty_owns", core_owns, 0);
    press(2'b01);
    tick(3);
    press(2'b10);
    tick(3);
    chk("empty_btn_addr", dmem_addr, 0);
    chk("empty_btn_valid", view_valid, 0);
    chk("empty_btn_index", view_index, 0);

    // Reset asserted while in FETCH
    mem[0] = 32'h0300_0000; mem[256] = 32'd5;
    finish = 1'b0;
    tick();
    finish = 1'b1;
    tick(2);
    chk("pre_rst_addr", dmem_addr, 1024);
    reset = 1'b1;
    tick();
    chk("mid_rst_owns", core_owns, 1);
    chk("mid_rst_addr", dmem_addr, 32'hABCD);
    chk("mid_rst_areas", num_areas, 0);
    chk("mid_rst_index", view_index, 0);
    chk("mid_rst_data", view_data, 0);
    chk("mid_rst_valid", view_valid, 0);
    reset = 1'b0; finish = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dmem_view_ctrl.md
Name: dmem_view_ctrl

Overview:
Owns the single data-memory port after the core asserts finish, and sequences result readout for the 7-segment and LED display.
- While the core runs, the core's data address passes straight through to the memory.
- After finish, the block reads the header word at address 0 to get the area count, then fetches result words at BASE_ADDR + 4*index.
- The index steps by button or by an auto-scroll timer.
- Sits between mipse, dmem and the display logic, replacing the ad-hoc address mux and area-count register at top level.

Parameters:
BASE_ADDR, 1024, byte address of result entry 0
IDX_W, 8, width of area count and index
AUTO_TICKS, 50000000, clk cycles per auto-scroll step (must be >= 2)

Ports:
clk  in  1  core clock
reset  in  1  synchronous active-high reset
finish  in  1  core finished; level signal
core_daddr  in  32  core data byte address
dmem_rd  in  32  dmem read data, combinational from dmem_addr
btn  in  2  btn[0]=next, btn[1]=prev; already synchronised, level
auto_en  in  1  enable auto-scroll
dmem_addr  out  32  byte address driven to dmem
num_areas  out  IDX_W  area count from header bits [31:24] (IDX_W=8)
view_index  out  IDX_W  currently displayed index
view_data  out  32  registered result word for view_index
view_valid  out  1  view_data matches view_index
core_owns  out  1  1 when dmem_addr = core_daddr

Behaviour:
Reset values:
- State CORE.
- num_areas=0, view_index=0, view_data=0, view_valid=0, core_owns=1.
- Timer=0, button history=0.

States:
- CORE:
  - dmem_addr=core_daddr (combinational); core_owns=1.
  - When finish=1, go to HDR.
- HDR:
  - dmem_addr=0; core_owns=0.
  - Next cycle: num_areas<=dmem_rd[31:24]; view_index<=0.
  - Go to FETCH if the value is nonzero, else EMPTY.
- EMPTY:
  - dmem_addr=0; view_valid=0.
  - Holds until finish falls.
- FETCH:
  - dmem_addr=BASE_ADDR + {view_index,2'b00} (32-bit, zero-extended); view_valid=0.
  - Exactly one cycle; next go to CAP.
- CAP:
  - dmem_addr unchanged; view_data<=dmem_rd; view_valid<=1.
  - Go to SHOW.
- SHOW:
  - dmem_addr held at the current entry address.
  - Waits for a step event.
  - On a step: update view_index, clear view_valid, go to FETCH.

Step events (evaluated only in SHOW):
- Rising edge of btn[0] alone = next; rising edge of btn[1] alone = prev.
- Both edges in the same cycle: ignored.
- Next: index num_areas-1 wraps to 0. Prev: index 0 wraps to num_areas-1.
- num_areas=1: a step refetches index 0.

Auto-scroll timer:
- Counts only in SHOW with auto_en=1; cleared otherwise.
- At AUTO_TICKS-1, generates a next step and clears.
- A button step in the same cycle takes priority, and the timer clears.

Latency: finish-high to first view_valid = 4 cycles (HDR, FETCH, CAP, then valid in SHOW).

Button edge history:
- Updated every cycle in all states.
- Edges outside SHOW are discarded.

Core restart:
- finish=0 in any non-CORE state: next cycle go to CORE.
- Clear view_valid; num_areas and view_index keep their values.
- Re-entry to HDR re-reads the header.

Reset asserted mid-sequence: all state returns to reset values on the next edge.

Decomposition:
Shared package/header: state encoding (CORE, HDR, EMPTY, FETCH, CAP, SHOW), BASE_ADDR default, header byte position constants (31:24).

Optional sub-module: btn_edge, a 2-bit rising-edge detector with a one-cycle pulse output.

The timer stays inline. Target ~180 lines of RTL.

Test Plan:
1. Reset, then finish=0 with core_daddr=0x1234 -> dmem_addr=0x1234, core_owns=1, view_valid=0.
2. Header word 0x03000000, entries 0x5/0x6/0x7 at 1024/1028/1032, finish=1 -> num_areas=3 one cycle after HDR; view_valid=1 with view_data=5 at cycle 4; dmem_addr=1024.
3. From index 2, pulse next -> view_index=0, view_data=5. From index 0, pulse prev -> view_index=2, view_data=7. Both buttons rising together -> no change.
4. Header 0x00000000 -> state EMPTY, num_areas=0, view_valid stays 0, dmem_addr=0; button pulses ignored.
5. AUTO_TICKS=4, auto_en=1, 3 areas -> index advances every 4 SHOW cycles plus 2 fetch cycles (0,1,2,0). A button press in the same cycle as a timer expiry gives a single step.
6. Deassert finish while in SHOW -> CORE next cycle, dmem_addr=core_daddr; reassert finish -> header re-read. Assert reset during FETCH -> all outputs at reset values next cycle.
